// File: rtl/lobinho_pkg.sv
// Shared definitions for the werewolf game controller: state codes and default sizes.
package lobinho_pkg;

    localparam int unsigned NUM_JOGADORES_PADRAO = 8;
    localparam int unsigned W_RODADA_PADRAO      = 8;
    localparam int unsigned W_ESTADO             = 5;

    typedef enum logic [W_ESTADO-1:0] {
        INICIAL        = 5'd0,
        RESETA_TUDO    = 5'd1,
        PREPARA_JOGO   = 5'd2,
        ARMAZENA_JOGO  = 5'd3,
        PREPARA_NOITE  = 5'd4,
        BUSCA_NOITE    = 5'd5,
        TURNO_NOITE    = 5'd6,
        FIM_NOITE      = 5'd7,
        VERIFICA_NOITE = 5'd8,
        PREPARA_DIA    = 5'd9,
        BUSCA_DIA      = 5'd10,
        TURNO_DIA      = 5'd11,
        FIM_DIA        = 5'd12,
        VERIFICA_DIA   = 5'd13,
        FIM_JOGO       = 5'd14
    } estado_t;

endpackage

// File: rtl/contador_jogador.sv
// Seat index counter; holds at the last seat instead of wrapping.
module contador_jogador
    import lobinho_pkg::*;
#(
    parameter int unsigned NUM_JOGADORES = NUM_JOGADORES_PADRAO,
    parameter int unsigned W_JOG         = $clog2(NUM_JOGADORES)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             zera,
    input  logic             inc,
    output logic [W_JOG-1:0] valor,
    output logic             fim
);

    localparam logic [W_JOG-1:0] ULTIMO = W_JOG'(NUM_JOGADORES - 1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valor <= '0;
        end else if (zera) begin
            valor <= '0;
        end else if (inc && !fim) begin
            valor <= valor + W_JOG'(1);
        end
    end

    assign fim = (valor == ULTIMO);

endmodule

// File: rtl/unidade_controle_rodadas.sv
// Moore controller sequencing setup and alternating night/day turns over the alive seats.
module unidade_controle_rodadas
    import lobinho_pkg::*;
#(
    parameter int unsigned NUM_JOGADORES = NUM_JOGADORES_PADRAO,
    parameter int unsigned W_JOG         = $clog2(NUM_JOGADORES),
    parameter int unsigned W_RODADA      = W_RODADA_PADRAO
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     jogar,
    input  logic                     passa,
    input  logic [NUM_JOGADORES-1:0] vivo,
    input  logic                     fim_jogo,
    output logic                     rst_global,
    output logic                     zera_CS,
    output logic                     e_seed_reg,
    output logic                     e_acao_noite,
    output logic                     e_voto,
    output logic                     aplica_noite,
    output logic                     aplica_voto,
    output logic                     fase_dia,
    output logic [W_JOG-1:0]         jogador_atual,
    output logic [W_RODADA-1:0]      rodada,
    output logic [W_ESTADO-1:0]      db_estado
);

    localparam logic [W_RODADA-1:0] RODADA_MAX = '1;

    estado_t estado;
    estado_t estado_prox;
    logic    zera_jog;
    logic    inc_jog;
    logic    fim_jog;
    logic    vivo_atual;

    contador_jogador #(
        .NUM_JOGADORES(NUM_JOGADORES),
        .W_JOG        (W_JOG)
    ) u_contador (
        .clock  (clock),
        .reset_n(reset_n),
        .zera   (zera_jog),
        .inc    (inc_jog),
        .valor  (jogador_atual),
        .fim    (fim_jog)
    );

    assign vivo_atual = vivo[jogador_atual];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado <= INICIAL;
        end else begin
            estado <= estado_prox;
        end
    end

    // Next state plus seat counter control; dead seats are skipped one per cycle.
    always_comb begin
        estado_prox = estado;
        zera_jog    = 1'b0;
        inc_jog     = 1'b0;
        case (estado)
            INICIAL: begin
                zera_jog = 1'b1;
                if (jogar) estado_prox = RESETA_TUDO;
            end
            RESETA_TUDO: begin
                zera_jog    = 1'b1;
                estado_prox = PREPARA_JOGO;
            end
            PREPARA_JOGO:  if (passa) estado_prox = ARMAZENA_JOGO;
            ARMAZENA_JOGO: estado_prox = PREPARA_NOITE;
            PREPARA_NOITE: begin
                zera_jog    = 1'b1;
                estado_prox = BUSCA_NOITE;
            end
            BUSCA_NOITE: begin
                if (vivo_atual)   estado_prox = TURNO_NOITE;
                else if (fim_jog) estado_prox = FIM_NOITE;
                else              inc_jog     = 1'b1;
            end
            TURNO_NOITE: begin
                if (passa) begin
                    if (fim_jog) begin
                        estado_prox = FIM_NOITE;
                    end else begin
                        inc_jog     = 1'b1;
                        estado_prox = BUSCA_NOITE;
                    end
                end
            end
            FIM_NOITE:      estado_prox = VERIFICA_NOITE;
            VERIFICA_NOITE: estado_prox = fim_jogo ? FIM_JOGO : PREPARA_DIA;
            PREPARA_DIA: begin
                zera_jog    = 1'b1;
                estado_prox = BUSCA_DIA;
            end
            BUSCA_DIA: begin
                if (vivo_atual)   estado_prox = TURNO_DIA;
                else if (fim_jog) estado_prox = FIM_DIA;
                else              inc_jog     = 1'b1;
            end
            TURNO_DIA: begin
                if (passa) begin
                    if (fim_jog) begin
                        estado_prox = FIM_DIA;
                    end else begin
                        inc_jog     = 1'b1;
                        estado_prox = BUSCA_DIA;
                    end
                end
            end
            FIM_DIA:      estado_prox = VERIFICA_DIA;
            VERIFICA_DIA: estado_prox = fim_jogo ? FIM_JOGO : PREPARA_NOITE;
            FIM_JOGO:     if (jogar) estado_prox = RESETA_TUDO;
            default:      estado_prox = INICIAL;
        endcase
    end

    // Completed day phases; cleared as soon as a (re)start is taken.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rodada <= '0;
        end else if (estado == INICIAL || estado_prox == RESETA_TUDO) begin
            rodada <= '0;
        end else if (estado == FIM_DIA && rodada != RODADA_MAX) begin
            rodada <= rodada + W_RODADA'(1);
        end
    end

    assign rst_global   = (estado == INICIAL) || (estado == RESETA_TUDO);
    assign zera_CS      = rst_global;
    assign e_seed_reg   = (estado == ARMAZENA_JOGO);
    assign e_acao_noite = (estado == TURNO_NOITE);
    assign e_voto       = (estado == TURNO_DIA);
    assign aplica_noite = (estado == FIM_NOITE);
    assign aplica_voto  = (estado == FIM_DIA);
    assign fase_dia     = (estado >= PREPARA_DIA) && (estado <= VERIFICA_DIA);
    assign db_estado    = estado;

endmodule

// File: tb/tb_unidade_controle_rodadas.sv
// Vector-table bench for the round controller; a second instance with a 2-bit round counter runs in lockstep.
module tb_unidade_controle_rodadas;

    localparam int unsigned N = 8;

    typedef struct {
        logic       jogar;
        logic       passa;
        logic [7:0] vivo;
        logic       fim;
        int         est;
        int         jog;
        int         rod;
        int         rod_sat;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       jogar;
    logic       passa;
    logic [7:0] vivo;
    logic       fim_jogo;

    logic       rst_global, zera_CS, e_seed_reg, e_acao_noite, e_voto;
    logic       aplica_noite, aplica_voto, fase_dia;
    logic [2:0] jogador_atual;
    logic [7:0] rodada;
    logic [4:0] db_estado;

    logic       s_rst_global, s_zera_CS, s_e_seed_reg, s_e_acao_noite, s_e_voto;
    logic       s_aplica_noite, s_aplica_voto, s_fase_dia;
    logic [2:0] s_jogador_atual;
    logic [1:0] s_rodada;
    logic [4:0] s_db_estado;

    logic [7:0] saidas;

    vec_t tabela[$];
    vec_t exp_q[$];
    vec_t mon_e;
    int   total = 0;
    int   bad   = 0;
    int   g_jog = 0;
    int   g_rod = 0;
    int   g_sat = 0;

    unidade_controle_rodadas #(.NUM_JOGADORES(N), .W_RODADA(8)) u_dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .jogar        (jogar),
        .passa        (passa),
        .vivo         (vivo),
        .fim_jogo     (fim_jogo),
        .rst_global   (rst_global),
        .zera_CS      (zera_CS),
        .e_seed_reg   (e_seed_reg),
        .e_acao_noite (e_acao_noite),
        .e_voto       (e_voto),
        .aplica_noite (aplica_noite),
        .aplica_voto  (aplica_voto),
        .fase_dia     (fase_dia),
        .jogador_atual(jogador_atual),
        .rodada       (rodada),
        .db_estado    (db_estado)
    );

    unidade_controle_rodadas #(.NUM_JOGADORES(N), .W_RODADA(2)) u_sat (
        .clock        (clock),
        .reset_n      (reset_n),
        .jogar        (jogar),
        .passa        (passa),
        .vivo         (vivo),
        .fim_jogo     (fim_jogo),
        .rst_global   (s_rst_global),
        .zera_CS      (s_zera_CS),
        .e_seed_reg   (s_e_seed_reg),
        .e_acao_noite (s_e_acao_noite),
        .e_voto       (s_e_voto),
        .aplica_noite (s_aplica_noite),
        .aplica_voto  (s_aplica_voto),
        .fase_dia     (s_fase_dia),
        .jogador_atual(s_jogador_atual),
        .rodada       (s_rodada),
        .db_estado    (s_db_estado)
    );

    always #5 clock = ~clock;

    assign saidas = {rst_global, zera_CS, e_seed_reg, e_acao_noite,
                     e_voto, aplica_noite, aplica_voto, fase_dia};

    // Expected Moore outputs for a state code, same bit order as saidas.
    function automatic logic [7:0] decodifica(input int est);
        logic rg;
        rg = (est == 0) || (est == 1);
        return {rg, rg, 1'(est == 3), 1'(est == 6), 1'(est == 11),
                1'(est == 7), 1'(est == 12), 1'((est >= 9) && (est <= 13))};
    endfunction

    function automatic int sat_inc(input int v, input int maxv);
        return (v >= maxv) ? maxv : v + 1;
    endfunction

    task automatic chk(input string nome, input int got, input int req);
        total++;
        if (got != req) begin
            bad++;
            $display("FAIL %s at %0t: got=%0d expected=%0d", nome, $time, got, req);
        end
    endtask

    task automatic add(input logic j, input logic p, input logic [7:0] v,
                       input logic f, input int est, input int jog);
        vec_t r;
        g_jog     = jog;
        r.jogar   = j;
        r.passa   = p;
        r.vivo    = v;
        r.fim     = f;
        r.est     = est;
        r.jog     = jog;
        r.rod     = g_rod;
        r.rod_sat = g_sat;
        tabela.push_back(r);
    endtask

    // Vectors for one phase starting in PREPARA_X; hold>0 keeps each turn open with the seat killed.
    task automatic add_fase(input bit dia, input logic [7:0] m, input int hold, input logic f_fim);
        int         base;
        logic [7:0] km;
        base = dia ? 9 : 4;
        add(1'b0, 1'b0, m, 1'b0, base + 1, 0);
        for (int s = 0; s < int'(N); s++) begin
            if (m[s]) begin
                km = m;
                if (hold > 0) km[s] = 1'b0;
                add(1'b0, 1'b0, m, 1'b0, base + 2, s);
                for (int h = 0; h < hold; h++) add(1'b1, 1'b0, km, 1'b1, base + 2, s);
                if (s == int'(N) - 1) add(1'(hold > 0), 1'b1, km, 1'b0, base + 3, s);
                else                  add(1'(hold > 0), 1'b1, km, 1'b0, base + 1, s + 1);
            end else begin
                if (s == int'(N) - 1) add(1'b0, 1'b0, m, 1'b0, base + 3, s);
                else                  add(1'b0, 1'b0, m, 1'b0, base + 1, s + 1);
            end
        end
        if (dia) begin
            g_rod = sat_inc(g_rod, 255);
            g_sat = sat_inc(g_sat, 3);
        end
        add(1'b0, 1'b0, m, 1'b0, base + 4, int'(N) - 1);
        add(1'b0, 1'b0, m, f_fim, f_fim ? 14 : (dia ? 4 : 9), int'(N) - 1);
    endtask

    task automatic run_tabela();
        foreach (tabela[i]) begin
            @(negedge clock);
            jogar    = tabela[i].jogar;
            passa    = tabela[i].passa;
            vivo     = tabela[i].vivo;
            fim_jogo = tabela[i].fim;
            exp_q.push_back(tabela[i]);
        end
        for (int k = 0; k < 8 && exp_q.size() != 0; k++) @(posedge clock);
        #2;
        chk("fila_pendente", exp_q.size(), 0);
        exp_q.delete();
        tabela.delete();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_estado"}, int'(db_estado), 0);
        chk({tag, "_jogador"}, int'(jogador_atual), 0);
        chk({tag, "_rodada"}, int'(rodada), 0);
        chk({tag, "_saidas"}, int'(saidas), int'(decodifica(0)));
        chk({tag, "_estado_sat"}, int'(s_db_estado), 0);
        chk({tag, "_rodada_sat"}, int'(s_rodada), 0);
    endtask

    // Scoreboard consumer: one expected record per clock edge, checked just after it.
    always @(posedge clock) begin
        #1;
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("estado", int'(db_estado), mon_e.est);
            chk("jogador", int'(jogador_atual), mon_e.jog);
            chk("rodada", int'(rodada), mon_e.rod);
            chk("saidas", int'(saidas), int'(decodifica(mon_e.est)));
            chk("estado_sat", int'(s_db_estado), mon_e.est);
            chk("rodada_sat", int'(s_rodada), mon_e.rod_sat);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n  = 1'b0;
        jogar    = 1'b0;
        passa    = 1'b0;
        vivo     = 8'hFF;
        fim_jogo = 1'b0;
        #12;
        chk_reset("reset_inicial");
        @(negedge clock);
        reset_n = 1'b1;

        // First game: setup, three night/day rounds, win in VERIFICA_DIA.
        add(1'b0, 1'b1, 8'hFF, 1'b1, 0, 0);
        add(1'b1, 1'b0, 8'hFF, 1'b0, 1, 0);
        add(1'b1, 1'b0, 8'hFF, 1'b0, 2, 0);
        add(1'b1, 1'b0, 8'hFF, 1'b0, 2, 0);
        add(1'b0, 1'b1, 8'hFF, 1'b0, 3, 0);
        add(1'b0, 1'b0, 8'hFF, 1'b0, 4, 0);
        add_fase(1'b0, 8'hFF, 2, 1'b0);
        add_fase(1'b1, 8'h00, 0, 1'b0);
        add_fase(1'b0, 8'hA5, 0, 1'b0);
        add_fase(1'b1, 8'h00, 0, 1'b0);
        add_fase(1'b0, 8'h00, 0, 1'b0);
        add_fase(1'b1, 8'hA5, 0, 1'b1);
        add(1'b0, 1'b1, 8'hFF, 1'b0, 14, 7);
        add(1'b0, 1'b0, 8'hFF, 1'b1, 14, 7);
        g_rod = 0;
        g_sat = 0;
        add(1'b1, 1'b0, 8'hFF, 1'b0, 1, 7);
        add(1'b0, 1'b0, 8'hFF, 1'b0, 2, 0);
        add(1'b0, 1'b1, 8'hFF, 1'b0, 3, 0);
        add(1'b0, 1'b0, 8'hFF, 1'b0, 4, 0);

        // Second game: five quick rounds push the 2-bit counter into saturation.
        for (int r = 0; r < 5; r++) begin
            add_fase(1'b0, 8'h00, 0, 1'b0);
            add_fase(1'b1, 8'h00, 0, 1'b0);
        end
        add_fase(1'b0, 8'h00, 0, 1'b0);
        add(1'b0, 1'b0, 8'hFF, 1'b0, 10, 0);
        add(1'b0, 1'b0, 8'hFF, 1'b0, 11, 0);
        for (int s = 1; s <= 3; s++) begin
            add(1'b0, 1'b1, 8'hFF, 1'b0, 10, s);
            add(1'b0, 1'b0, 8'hFF, 1'b0, 11, s);
        end
        run_tabela();

        // Asynchronous reset while TURNO_DIA holds seat 3 with rounds counted.
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset("reset_turno");
        @(negedge clock);
        reset_n = 1'b1;

        // Restart after reset, then a night-phase win and a combined jogar+passa in FIM_JOGO.
        g_rod = 0;
        g_sat = 0;
        add(1'b0, 1'b0, 8'hFF, 1'b0, 0, 0);
        add(1'b1, 1'b0, 8'hFF, 1'b0, 1, 0);
        add(1'b0, 1'b0, 8'hFF, 1'b0, 2, 0);
        add(1'b0, 1'b1, 8'hFF, 1'b0, 3, 0);
        add(1'b0, 1'b0, 8'hFF, 1'b0, 4, 0);
        add_fase(1'b0, 8'h00, 0, 1'b1);
        add(1'b1, 1'b1, 8'hFF, 1'b0, 1, 7);
        add(1'b0, 1'b0, 8'hFF, 1'b0, 2, 0);
        run_tabela();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
